// File: rtl/write_stage.sv
// Commit stage: retires execute results to the register file and flags, and
// performs stores with a wait-state handshake plus address-register post-adjust.
module write_stage #(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] in_pc,
    input  logic [4:0]  in_destination_register,
    input  logic        in_is_writing_memory,
    input  logic [3:0]  in_flags,
    input  logic [31:0] in_destination_value,
    input  logic [31:0] in_adjustment_value,
    input  logic        in_has_flushed,
    output logic        in_hold,
    input  logic [31:0] address_value,
    output logic        rf_write,
    output logic [4:0]  rf_index,
    output logic [31:0] rf_value,
    output logic        flags_write,
    output logic [3:0]  flags_value,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data,
    input  logic        mem_wait,
    output logic        retired,
    output logic [31:0] retired_pc,
    output logic        bus_error
);

    localparam int unsigned CW = ($clog2(MAX_WAIT + 1) > 8) ? $clog2(MAX_WAIT + 1) : 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_STORE,
        S_UPDATE
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_wait_cnt;
    logic [31:0]   r_adjust;
    logic [4:0]    r_index;
    logic [31:0]   r_pc;

    logic w_accept;
    logic w_timeout;
    logic w_do_update;

    assign in_hold     = (r_state != S_IDLE);
    assign w_accept    = (r_state == S_IDLE) && in_valid && !in_has_flushed;
    // MAX_WAIT wait cycles are tolerated; the next one still waiting aborts.
    assign w_timeout   = mem_wait && (r_wait_cnt == CW'(MAX_WAIT));
    assign w_do_update = (r_adjust != '0) && (r_index != '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_wait_cnt  <= '0;
            r_adjust    <= '0;
            r_index     <= '0;
            r_pc        <= '0;
            rf_write    <= 1'b0;
            rf_index    <= '0;
            rf_value    <= '0;
            flags_write <= 1'b0;
            flags_value <= '0;
            mem_write   <= 1'b0;
            mem_address <= '0;
            mem_data    <= '0;
            retired     <= 1'b0;
            retired_pc  <= '0;
            bus_error   <= 1'b0;
        end else begin
            rf_write    <= 1'b0;
            flags_write <= 1'b0;
            retired     <= 1'b0;
            bus_error   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (in_is_writing_memory) begin
                            mem_write   <= 1'b1;
                            mem_address <= address_value;
                            mem_data    <= in_destination_value;
                            r_adjust    <= in_adjustment_value;
                            r_index     <= in_destination_register;
                            r_pc        <= in_pc;
                            r_wait_cnt  <= '0;
                            r_state     <= S_STORE;
                        end else begin
                            // Flags port order is {negative, carry, overflow, zero}.
                            flags_write <= 1'b1;
                            flags_value <= {in_flags[2], in_flags[3], in_flags[1], in_flags[0]};
                            rf_write    <= (in_destination_register != '0);
                            rf_index    <= in_destination_register;
                            rf_value    <= in_destination_value;
                            retired     <= 1'b1;
                            retired_pc  <= in_pc;
                        end
                    end
                end
                S_STORE: begin
                    if (!mem_wait) begin
                        mem_write  <= 1'b0;
                        retired    <= 1'b1;
                        retired_pc <= r_pc;
                        if (w_do_update) begin
                            rf_write <= 1'b1;
                            rf_index <= r_index;
                            rf_value <= mem_address + r_adjust;
                            r_state  <= S_UPDATE;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else if (w_timeout) begin
                        mem_write <= 1'b0;
                        bus_error <= 1'b1;
                        r_state   <= S_IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                S_UPDATE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_write_stage.sv
// Scoreboard bench for write_stage: a transaction-level model predicts every
// strobe with its cycle; a monitor matches DUT strobes against that queue.
module tb_write_stage;

    localparam int unsigned MAXW = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [4:0]  in_destination_register;
    logic        in_is_writing_memory;
    logic [3:0]  in_flags;
    logic [31:0] in_destination_value;
    logic [31:0] in_adjustment_value;
    logic        in_has_flushed;
    logic        in_hold;
    logic [31:0] address_value;
    logic        rf_write;
    logic [4:0]  rf_index;
    logic [31:0] rf_value;
    logic        flags_write;
    logic [3:0]  flags_value;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_data;
    logic        mem_wait;
    logic        retired;
    logic [31:0] retired_pc;
    logic        bus_error;

    write_stage #(.MAX_WAIT(MAXW)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_pc(in_pc),
        .in_destination_register(in_destination_register),
        .in_is_writing_memory(in_is_writing_memory), .in_flags(in_flags),
        .in_destination_value(in_destination_value),
        .in_adjustment_value(in_adjustment_value), .in_has_flushed(in_has_flushed),
        .in_hold(in_hold), .address_value(address_value),
        .rf_write(rf_write), .rf_index(rf_index), .rf_value(rf_value),
        .flags_write(flags_write), .flags_value(flags_value),
        .mem_write(mem_write), .mem_address(mem_address), .mem_data(mem_data),
        .mem_wait(mem_wait), .retired(retired), .retired_pc(retired_pc),
        .bus_error(bus_error)
    );

    always #5 clock = ~clock;

    // kind: 0 rf write, 1 flags, 2 retire, 3 store beat, 4 bus error
    typedef struct {
        int          kind;
        int          cyc;
        logic [31:0] a;
        logic [31:0] b;
    } ev_t;

    ev_t   q[$];
    int    cyc = 0;
    int    h_from = -1;
    int    h_to = -2;
    int    errors = 0;
    int    checks = 0;
    bit    mon_en = 1'b0;
    int    cur_w = 0;
    int    slave_k = 0;
    string kn[5] = '{"rf", "flags", "retire", "mem", "bus_error"};

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int k, input int c, input logic [31:0] a, input logic [31:0] b);
        ev_t e;
        e.kind = k; e.cyc = c; e.a = a; e.b = b;
        q.push_back(e);
    endtask

    // Memory slave: holds mem_wait high for the first cur_w beats of a store.
    always @(negedge clock) begin
        if (mem_write) begin
            mem_wait = (slave_k < cur_w);
            slave_k++;
        end else begin
            slave_k  = 0;
            mem_wait = 1'($urandom_range(0, 1));
        end
    end

    always @(negedge clock) begin : monitor
        logic        st [5];
        logic [31:0] av [5];
        logic [31:0] bv [5];
        logic        exp_hold;
        int          idx;
        if (mon_en) begin
            exp_hold = (cyc >= h_from) && (cyc <= h_to);
            chk("in_hold", 32'(in_hold), 32'(exp_hold));
            st[0] = rf_write;    av[0] = 32'(rf_index);    bv[0] = rf_value;
            st[1] = flags_write; av[1] = 32'(flags_value); bv[1] = '0;
            st[2] = retired;     av[2] = retired_pc;       bv[2] = '0;
            st[3] = mem_write;   av[3] = mem_address;      bv[3] = mem_data;
            st[4] = bus_error;   av[4] = '0;               bv[4] = '0;
            for (int k = 0; k < 5; k++) begin
                if (st[k]) begin
                    idx = -1;
                    for (int i = 0; i < q.size(); i++)
                        if (idx < 0 && q[i].kind == k && q[i].cyc == cyc) idx = i;
                    if (idx < 0) begin
                        checks++; errors++;
                        $display("FAIL %s_unexpected: got strobe=1 expected 0 (cycle %0d)", kn[k], cyc);
                    end else begin
                        chk({kn[k], "_a"}, av[k], q[idx].a);
                        chk({kn[k], "_b"}, bv[k], q[idx].b);
                        q.delete(idx);
                    end
                end
            end
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (q[i].cyc <= cyc) begin
                    checks++; errors++;
                    $display("FAIL %s_missing: got strobe=0 expected 1 (cycle %0d)", kn[q[i].kind], q[i].cyc);
                    q.delete(i);
                end
            end
        end
    end

    // Present one instruction, wait until it is accepted, and predict its effects.
    task automatic send(input bit fl, input bit st, input logic [4:0] d, input logic [31:0] pc,
                        input logic [31:0] val, input logic [31:0] adj, input logic [31:0] addr,
                        input logic [3:0] f, input int w);
        int   guard;
        int   c;
        bit   upd;
        logic carry, neg, ovf, zero;
        in_valid = 1'b1; in_has_flushed = fl; in_is_writing_memory = st;
        in_destination_register = d; in_pc = pc; in_destination_value = val;
        in_adjustment_value = adj; address_value = addr; in_flags = f;
        guard = 0;
        @(negedge clock);
        while (in_hold && guard < 100) begin
            guard++;
            @(negedge clock);
        end
        if (in_hold) begin
            checks++; errors++;
            $display("FAIL accept_timeout: got in_hold=1 expected 0");
        end
        c = cyc;
        if (!fl) begin
            if (!st) begin
                {carry, neg, ovf, zero} = f;
                if (d != 0) push(0, c + 1, 32'(d), val);
                push(1, c + 1, 32'({neg, carry, ovf, zero}), '0);
                push(2, c + 1, pc, '0);
            end else begin
                cur_w  = w;
                h_from = c + 1;
                if (w <= int'(MAXW)) begin
                    for (int k = 0; k <= w; k++) push(3, c + 1 + k, addr, val);
                    upd = (d != 0) && (adj != 0);
                    if (upd) push(0, c + 2 + w, 32'(d), addr + adj);
                    push(2, c + 2 + w, pc, '0);
                    h_to = upd ? c + 2 + w : c + 1 + w;
                end else begin
                    for (int k = 0; k <= int'(MAXW); k++) push(3, c + 1 + k, addr, val);
                    push(4, c + 2 + int'(MAXW), '0, '0);
                    h_to = c + 1 + int'(MAXW);
                end
            end
        end
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            in_is_writing_memory = 1'($urandom);
            in_destination_register = 5'($urandom);
            in_destination_value = $urandom;
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_in_hold"}, 32'(in_hold), '0);
        chk({tag, "_rf_write"}, 32'(rf_write), '0);
        chk({tag, "_rf_index"}, 32'(rf_index), '0);
        chk({tag, "_rf_value"}, rf_value, '0);
        chk({tag, "_flags_write"}, 32'(flags_write), '0);
        chk({tag, "_flags_value"}, 32'(flags_value), '0);
        chk({tag, "_mem_write"}, 32'(mem_write), '0);
        chk({tag, "_mem_address"}, mem_address, '0);
        chk({tag, "_mem_data"}, mem_data, '0);
        chk({tag, "_retired"}, 32'(retired), '0);
        chk({tag, "_retired_pc"}, retired_pc, '0);
        chk({tag, "_bus_error"}, 32'(bus_error), '0);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_pc = '0; in_destination_register = '0;
        in_is_writing_memory = 1'b0; in_flags = '0; in_destination_value = '0;
        in_adjustment_value = '0; in_has_flushed = 1'b0; address_value = '0;
        mem_wait = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        check_all_zero("reset");
        mon_en = 1'b1;

        send(0, 0, 5'd3, 32'h100, 32'h1234, 32'h0, 32'h0, 4'b0001, 0);
        send(0, 0, 5'd0, 32'h104, 32'h1234, 32'h0, 32'h0, 4'b0001, 0);
        send(1, 0, 5'd3, 32'h108, 32'h1234, 32'h0, 32'h0, 4'b0001, 0);
        idle_cycles(2);
        send(0, 1, 5'd5, 32'h10c, 32'hCAFE, 32'h4, 32'h2000, 4'b0000, 0);
        send(0, 0, 5'd6, 32'h110, 32'h55, 32'h0, 32'h0, 4'b0110, 0);
        send(0, 1, 5'd7, 32'h114, 32'hBEEF, 32'h8, 32'h3000, 4'b0000, 3);
        send(0, 0, 5'd8, 32'h118, 32'h66, 32'h0, 32'h0, 4'b1000, 0);
        send(0, 1, 5'd9, 32'h11c, 32'h1, 32'h10, 32'h4000, 4'b0000, int'(MAXW));
        send(0, 1, 5'd9, 32'h120, 32'h2, 32'h10, 32'h5000, 4'b0000, 50);
        send(0, 1, 5'd0, 32'h124, 32'h3, 32'h10, 32'h6000, 4'b0000, 1);
        send(0, 1, 5'd4, 32'h128, 32'h4, 32'h0, 32'h7000, 4'b0000, 0);
        send(0, 1, 5'd4, 32'h12c, 32'h5, 32'h1, 32'hFFFF_FFFF, 4'b0000, 0);
        send(1, 1, 5'd4, 32'h130, 32'h6, 32'h4, 32'h8000, 4'b0000, 0);
        for (int i = 0; i < 4; i++)
            send(0, 0, 5'(i + 10), 32'h200 + 32'(4 * i), $urandom, 32'h0, 32'h0, 4'($urandom), 0);

        for (int i = 0; i < 250; i++) begin
            send(($urandom_range(0, 7) == 0), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
                 $urandom, $urandom,
                 ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom,
                 $urandom, 4'($urandom), $urandom_range(0, MAXW + 2));
            if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 2));
        end

        send(0, 1, 5'd12, 32'h300, 32'hD00D, 32'h4, 32'h9000, 4'b0000, 10);
        @(posedge clock);
        #1;
        mon_en = 1'b0;
        reset  = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        check_all_zero("midstore_reset");
        q.delete();
        h_from = -1;
        h_to   = -2;
        mon_en = 1'b1;
        send(0, 0, 5'd2, 32'h400, 32'h77, 32'h0, 32'h0, 4'b0101, 0);
        send(0, 1, 5'd2, 32'h404, 32'h88, 32'h4, 32'hA000, 4'b0000, 2);

        idle_cycles(int'(MAXW) + 8);
        @(negedge clock);
        #1;
        chk("drain_queue_empty", 32'(q.size()), '0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
